// File: rtl/adc_red_ir_sampler.sv
// Red/IR pulse-oximeter front-end sequencer.
// Each frame lights the red LED, lets it settle, reads one 8-bit sample from a serial ADC, then
// does the same with the IR LED. Both results are published together with a one-cycle strobe.
// The rest of the frame is idle so that strobes are exactly FRAME_CYC cycles apart.
// Illegal parameter combinations are the integrator's responsibility. They are
// SETTLE_CYC outside 1..255, SCLK_DIV outside 1..15, and FRAME_CYC too short to hold both
// conversions.
module adc_red_ir_sampler #(
  parameter int unsigned SETTLE_CYC = 16,
  parameter int unsigned SCLK_DIV   = 2,
  parameter int unsigned FRAME_CYC  = 200
) (
  input  logic       CLK_Filter,
  input  logic       rst_n,
  input  logic       Enable,
  input  logic       ADC_SDO,
  output logic       ADC_CS_n,
  output logic       ADC_SCLK,
  output logic       LED_RED_EN,
  output logic       LED_IR_EN,
  output logic [7:0] RED_ADC_Value,
  output logic [7:0] IR_ADC_Value,
  output logic       Sample_Valid,
  output logic       Busy
);

  localparam int unsigned FRAME_W = (FRAME_CYC > 1) ? $clog2(FRAME_CYC) : 1;
  localparam logic [FRAME_W-1:0] FRAME_LAST  = FRAME_W'(FRAME_CYC - 1);
  localparam logic [7:0]         SETTLE_LAST = 8'(SETTLE_CYC - 1);
  // Conversion is 1 setup cycle plus 8 bits of 2*SCLK_DIV cycles.
  localparam logic [7:0]         CONV_LAST   = 8'(16 * SCLK_DIV);
  localparam logic [3:0]         HALF_LAST   = 4'(SCLK_DIV - 1);

  typedef enum logic [2:0] {
    StIdle, StRedSettle, StRedConv, StIrSettle, StIrConv, StDone, StWait
  } state_e;

  state_e             state_q, state_d;
  logic [FRAME_W-1:0] frame_q, frame_d;
  logic [7:0]         step_q, step_d;
  logic [3:0]         half_q, half_d;
  logic               sclk_hi_q, sclk_hi_d;
  logic [7:0]         shift_q, shift_d;
  logic [7:0]         shadow_q, shadow_d;
  logic [7:0]         red_q, red_d;
  logic [7:0]         ir_q, ir_d;
  logic               in_conv;
  logic               sample_bit;
  logic [7:0]         shift_in;

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge CLK_Filter) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      frame_q   <= '0;
      step_q    <= '0;
      half_q    <= '0;
      sclk_hi_q <= 1'b0;
      shift_q   <= '0;
      shadow_q  <= '0;
      red_q     <= '0;
      ir_q      <= '0;
    end else begin
      state_q   <= state_d;
      frame_q   <= frame_d;
      step_q    <= step_d;
      half_q    <= half_d;
      sclk_hi_q <= sclk_hi_d;
      shift_q   <= shift_d;
      shadow_q  <= shadow_d;
      red_q     <= red_d;
      ir_q      <= ir_d;
    end
  end

  // Next-state: frame sequencing, SCLK phase tracking and serial capture.
  always_comb begin
    state_d    = state_q;
    frame_d    = frame_q + FRAME_W'(1);
    step_d     = step_q + 8'd1;
    half_d     = half_q;
    sclk_hi_d  = sclk_hi_q;
    shift_d    = shift_q;
    shadow_d   = shadow_q;
    red_d      = red_q;
    ir_d       = ir_q;
    sample_bit = 1'b0;

    in_conv  = (state_q == StRedConv) || (state_q == StIrConv);
    // Byte as it stands once the bit on ADC_SDO is taken; used on the final sample.
    shift_in = {shift_q[6:0], ADC_SDO};

    // SCLK phases only run after the setup cycle (step 0) of a conversion.
    if (in_conv && (step_q != 8'd0)) begin
      if (half_q == HALF_LAST) begin
        half_d     = 4'd0;
        sclk_hi_d  = ~sclk_hi_q;
        sample_bit = sclk_hi_q;
      end else begin
        half_d = half_q + 4'd1;
      end
    end
    if (sample_bit) begin
      shift_d = shift_in;
    end

    case (state_q)
      StIdle: begin
        frame_d = '0;
        step_d  = 8'd0;
        if (Enable) begin
          state_d = StRedSettle;
        end
      end
      StRedSettle: begin
        if (step_q == SETTLE_LAST) begin
          state_d   = StRedConv;
          step_d    = 8'd0;
          half_d    = 4'd0;
          sclk_hi_d = 1'b0;
        end
      end
      StRedConv: begin
        if (step_q == CONV_LAST) begin
          state_d  = StIrSettle;
          step_d   = 8'd0;
          shadow_d = shift_in;
        end
      end
      StIrSettle: begin
        if (step_q == SETTLE_LAST) begin
          state_d   = StIrConv;
          step_d    = 8'd0;
          half_d    = 4'd0;
          sclk_hi_d = 1'b0;
        end
      end
      StIrConv: begin
        if (step_q == CONV_LAST) begin
          state_d = StDone;
          step_d  = 8'd0;
          red_d   = shadow_q;
          ir_d    = shift_in;
        end
      end
      StDone: begin
        state_d = StWait;
        step_d  = 8'd0;
      end
      StWait: begin
        step_d = 8'd0;
        if (frame_q == FRAME_LAST) begin
          state_d = StRedSettle;
          frame_d = '0;
        end
      end
      default: begin
        state_d = StIdle;
        frame_d = '0;
        step_d  = 8'd0;
      end
    endcase

    // Dropping Enable aborts the frame; published values are left untouched.
    if ((state_q != StIdle) && !Enable) begin
      state_d   = StIdle;
      frame_d   = '0;
      step_d    = 8'd0;
      half_d    = 4'd0;
      sclk_hi_d = 1'b0;
      shift_d   = '0;
      shadow_d  = shadow_q;
      red_d     = red_q;
      ir_d      = ir_q;
    end
  end

  // Output decode from the registered state.
  always_comb begin
    ADC_CS_n     = 1'b1;
    ADC_SCLK     = 1'b0;
    LED_RED_EN   = 1'b0;
    LED_IR_EN    = 1'b0;
    Sample_Valid = 1'b0;
    Busy         = (state_q != StIdle);
    case (state_q)
      StRedSettle: LED_RED_EN = 1'b1;
      StRedConv: begin
        LED_RED_EN = 1'b1;
        ADC_CS_n   = 1'b0;
        ADC_SCLK   = (step_q != 8'd0) && sclk_hi_q;
      end
      StIrSettle: LED_IR_EN = 1'b1;
      StIrConv: begin
        LED_IR_EN = 1'b1;
        ADC_CS_n  = 1'b0;
        ADC_SCLK  = (step_q != 8'd0) && sclk_hi_q;
      end
      StDone:  Sample_Valid = 1'b1;
      default: ;
    endcase
  end

  assign RED_ADC_Value = red_q;
  assign IR_ADC_Value  = ir_q;

endmodule

// File: tb/tb_adc_red_ir_sampler.sv
// Bench for adc_red_ir_sampler: two instances (default timing and fastest timing) checked every
// cycle against a frame-position model, plus directed and randomized scenarios.
module tb_adc_red_ir_sampler;

  localparam int S0 = 16;
  localparam int D0 = 2;
  localparam int F0 = 200;
  localparam int S1 = 1;
  localparam int D1 = 1;
  localparam int F1 = 40;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [1:0] rstn_v, en_v, sdo_v;
  logic [1:0] cs_n_w, sclk_w, red_en_w, ir_en_w, valid_w, busy_w;
  logic [7:0] red_val0, ir_val0, red_val1, ir_val1;

  logic [7:0] red_word [2];
  logic [7:0] ir_word  [2];

  // Model state: frame position (-1 = idle) and expected published values.
  int         m_pos     [2];
  logic [7:0] m_red     [2];
  logic [7:0] m_ir      [2];
  logic [7:0] m_lat_red [2];
  logic [7:0] m_lat_ir  [2];

  int checks = 0;
  int errors = 0;

  adc_red_ir_sampler #(.SETTLE_CYC(S0), .SCLK_DIV(D0), .FRAME_CYC(F0)) dut0 (
    .CLK_Filter(clk), .rst_n(rstn_v[0]), .Enable(en_v[0]), .ADC_SDO(sdo_v[0]),
    .ADC_CS_n(cs_n_w[0]), .ADC_SCLK(sclk_w[0]), .LED_RED_EN(red_en_w[0]),
    .LED_IR_EN(ir_en_w[0]), .RED_ADC_Value(red_val0), .IR_ADC_Value(ir_val0),
    .Sample_Valid(valid_w[0]), .Busy(busy_w[0])
  );

  adc_red_ir_sampler #(.SETTLE_CYC(S1), .SCLK_DIV(D1), .FRAME_CYC(F1)) dut1 (
    .CLK_Filter(clk), .rst_n(rstn_v[1]), .Enable(en_v[1]), .ADC_SDO(sdo_v[1]),
    .ADC_CS_n(cs_n_w[1]), .ADC_SCLK(sclk_w[1]), .LED_RED_EN(red_en_w[1]),
    .LED_IR_EN(ir_en_w[1]), .RED_ADC_Value(red_val1), .IR_ADC_Value(ir_val1),
    .Sample_Valid(valid_w[1]), .Busy(busy_w[1])
  );

  // Serial ADC: loads the word for the lit LED when CS falls, presents MSB first and
  // advances on each SCLK falling edge.
  logic [7:0] adc_sh [2] = '{8'h00, 8'h00};
  logic [1:0] prev_cs   = 2'b11;
  logic [1:0] prev_sclk = 2'b00;
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (prev_cs[i] && !cs_n_w[i]) adc_sh[i] = red_en_w[i] ? red_word[i] : ir_word[i];
      else if (prev_sclk[i] && !sclk_w[i]) adc_sh[i] = {adc_sh[i][6:0], 1'b0};
      prev_cs[i]   = cs_n_w[i];
      prev_sclk[i] = sclk_w[i];
      sdo_v[i]     = adc_sh[i][7];
    end
  end

  function automatic int cfg_s(int i); return (i == 0) ? S0 : S1; endfunction
  function automatic int cfg_d(int i); return (i == 0) ? D0 : D1; endfunction
  function automatic int cfg_f(int i); return (i == 0) ? F0 : F1; endfunction

  function automatic logic sck(int off, int d);
    if (off == 0) return 1'b0;
    return ((off - 1) % (2 * d)) >= d;
  endfunction

  // Expected {cs_n, sclk, led_red, led_ir, valid, busy} at a frame position.
  function automatic logic [5:0] exp_ctl(int pos, int s, int d);
    int c = 1 + 16 * d;
    if (pos < 0) return 6'b100000;
    if (pos < s) return 6'b101001;
    if (pos < s + c) return {1'b0, sck(pos - s, d), 4'b1001};
    if (pos < 2 * s + c) return 6'b100101;
    if (pos < 2 * s + 2 * c) return {1'b0, sck(pos - 2 * s - c, d), 4'b0101};
    if (pos == 2 * s + 2 * c) return 6'b100011;
    return 6'b100001;
  endfunction

  task automatic chk(string tag, logic [15:0] obs, logic [15:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_step(int i);
    int s = cfg_s(i);
    int c = 1 + 16 * cfg_d(i);
    int f = cfg_f(i);
    if (!rstn_v[i]) begin
      m_pos[i] = -1;
      m_red[i] = 8'h00;
      m_ir[i]  = 8'h00;
    end else if (m_pos[i] < 0) begin
      m_pos[i] = en_v[i] ? 0 : -1;
    end else if (!en_v[i]) begin
      m_pos[i] = -1;
    end else begin
      m_pos[i] = (m_pos[i] == f - 1) ? 0 : m_pos[i] + 1;
      if (m_pos[i] == s) m_lat_red[i] = red_word[i];
      if (m_pos[i] == 2 * s + c) m_lat_ir[i] = ir_word[i];
      if (m_pos[i] == 2 * s + 2 * c) begin
        m_red[i] = m_lat_red[i];
        m_ir[i]  = m_lat_ir[i];
      end
    end
  endtask

  task automatic check_dut(int i);
    logic [5:0] obs;
    logic [7:0] ored, oir;
    obs  = {cs_n_w[i], sclk_w[i], red_en_w[i], ir_en_w[i], valid_w[i], busy_w[i]};
    ored = (i == 0) ? red_val0 : red_val1;
    oir  = (i == 0) ? ir_val0 : ir_val1;
    chk($sformatf("dut%0d ctl pos=%0d", i, m_pos[i]), {10'd0, obs},
        {10'd0, exp_ctl(m_pos[i], cfg_s(i), cfg_d(i))});
    chk($sformatf("dut%0d values pos=%0d", i, m_pos[i]), {ored, oir}, {m_red[i], m_ir[i]});
    chk($sformatf("dut%0d leds_exclusive", i), {15'd0, red_en_w[i] & ir_en_w[i]}, 16'd0);
  endtask

  // One clock: model follows the inputs seen at the edge, outputs checked 1 time unit later.
  task automatic tick();
    @(posedge clk);
    model_step(0);
    model_step(1);
    #1;
    check_dut(0);
    check_dut(1);
  endtask

  initial begin
    int vcyc;
    int rises;
    int convs;
    logic psclk, pcs;
    int cycles0;

    rstn_v = 2'b00;
    en_v   = 2'b00;
    red_word = '{8'h00, 8'h00};
    ir_word  = '{8'h00, 8'h00};
    m_pos    = '{-1, -1};
    m_red    = '{8'h00, 8'h00};
    m_ir     = '{8'h00, 8'h00};
    m_lat_red = '{8'h00, 8'h00};
    m_lat_ir  = '{8'h00, 8'h00};

    // Reset state.
    repeat (3) tick();
    chk("reset busy", {15'd0, busy_w[0]}, 16'd0);

    // Single frame, red 0xA5 / IR 0x3C: strobe only at cycle 98.
    rstn_v = 2'b11;
    red_word[0] = 8'hA5;
    ir_word[0]  = 8'h3C;
    en_v[0] = 1'b1;
    vcyc = -1;
    for (int j = 0; j < F0; j++) begin
      tick();
      if (valid_w[0] && vcyc < 0) vcyc = j;
    end
    chk("first strobe cycle", 16'(vcyc), 16'd98);
    chk("frame1 red", {8'd0, red_val0}, 16'h00A5);
    chk("frame1 ir", {8'd0, ir_val0}, 16'h003C);

    // Three back-to-back frames with different red data.
    for (int k = 0; k < 3; k++) begin
      red_word[0] = (k == 0) ? 8'h01 : (k == 1) ? 8'h80 : 8'hFF;
      ir_word[0]  = 8'(8'h10 + k);
      vcyc = -1;
      for (int j = 0; j < F0; j++) begin
        tick();
        if (valid_w[0] && vcyc < 0) vcyc = j;
      end
      chk($sformatf("frame%0d strobe cycle", k + 2), 16'(vcyc), 16'd98);
      chk($sformatf("frame%0d red", k + 2), {8'd0, red_val0}, {8'd0, red_word[0]});
    end

    // Frame with 0x11/0x22, then abort at cycle 70 of the next frame.
    red_word[0] = 8'h11;
    ir_word[0]  = 8'h22;
    repeat (F0) tick();
    red_word[0] = 8'h33;
    ir_word[0]  = 8'h44;
    repeat (71) tick();
    en_v[0] = 1'b0;
    tick();
    chk("abort busy", {15'd0, busy_w[0]}, 16'd0);
    chk("abort values", {red_val0, ir_val0}, 16'h1122);
    repeat (5) tick();

    // Reset pulse at cycle 30, then restart with Enable held.
    en_v[0] = 1'b1;
    repeat (31) tick();
    rstn_v[0] = 1'b0;
    tick();
    chk("midframe reset values", {red_val0, ir_val0}, 16'h0000);
    chk("midframe reset cs_n", {15'd0, cs_n_w[0]}, 16'd1);
    rstn_v[0] = 1'b1;
    repeat (10) tick();

    // Randomized enable drops, resets and data.
    cycles0 = 0;
    while (cycles0 < 4000) begin
      if (m_pos[0] < 0 || m_pos[0] > 2 * S0 + 2 * (1 + 16 * D0)) begin
        if ($urandom_range(0, 3) == 0) begin
          red_word[0] = 8'($urandom_range(0, 255));
          ir_word[0]  = 8'($urandom_range(0, 255));
        end
      end
      en_v[0]   = ($urandom_range(0, 299) != 0);
      rstn_v[0] = ($urandom_range(0, 1499) != 0);
      tick();
      cycles0++;
    end
    rstn_v[0] = 1'b1;
    en_v[0]   = 1'b0;
    tick();

    // Fastest timing instance: 8 one-cycle SCLK pulses per conversion, DONE at cycle 36.
    red_word[1] = 8'h5A;
    ir_word[1]  = 8'hC3;
    en_v[1] = 1'b1;
    vcyc  = -1;
    rises = 0;
    convs = 0;
    psclk = 1'b0;
    pcs   = 1'b1;
    for (int j = 0; j < 2 * F1; j++) begin
      tick();
      if (valid_w[1] && vcyc < 0) vcyc = j;
      if (!psclk && sclk_w[1]) rises++;
      if (!pcs && cs_n_w[1]) begin
        chk($sformatf("dut1 sclk rises conv%0d", convs), 16'(rises), 16'd8);
        rises = 0;
        convs++;
      end
      psclk = sclk_w[1];
      pcs   = cs_n_w[1];
    end
    chk("dut1 strobe cycle", 16'(vcyc), 16'd36);
    chk("dut1 conversions", 16'(convs), 16'd4);
    chk("dut1 values", {red_val1, ir_val1}, 16'h5AC3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
